// File: rtl/hpdcache_ram_1rw_port.sv
`default_nettype none
// ============================================================================
// Module   : hpdcache_ram_1rw_port
// Brief    : Request/response front-end for a 1RW masked-write SRAM with an
//            optional zero-fill sequence after reset and a 2-entry read FIFO.
// Revision : 1.0
// ============================================================================
module hpdcache_ram_1rw_port #(
  parameter int unsigned ADDR_SIZE     = 6,
  parameter int unsigned DATA_SIZE     = 64,
  parameter int unsigned DEPTH         = 2**ADDR_SIZE,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADDR_SIZE-1:0] req_addr_i,
  input  logic [DATA_SIZE-1:0] req_wdata_i,
  input  logic [DATA_SIZE-1:0] req_wmask_i,

  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATA_SIZE-1:0] rsp_rdata_o,

  output logic                 init_done_o,

  output logic                 ram_cs_o,
  output logic                 ram_we_o,
  output logic [ADDR_SIZE-1:0] ram_addr_o,
  output logic [DATA_SIZE-1:0] ram_wdata_o,
  output logic [DATA_SIZE-1:0] ram_wmask_o,
  input  logic [DATA_SIZE-1:0] ram_rdata_i
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_SIZE-1:0] C_LAST_ADDR = ADDR_SIZE'(DEPTH - 1);
  localparam state_t               C_RST_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

  state_t                 r_state;
  logic [ADDR_SIZE-1:0]   r_init_cnt;

  logic [DATA_SIZE-1:0]   r_fifo_mem [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_fifo_cnt;
  logic                   r_rd_pending;

  logic                   w_run;
  logic [1:0]             w_occupancy;
  logic                   w_req_ready;
  logic                   w_accept;
  logic                   w_fifo_empty;
  logic                   w_rsp_valid;
  logic                   w_push;
  logic                   w_pop;

  // Control state and init address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= C_RST_STATE;
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + ADDR_SIZE'(1);
      if (r_init_cnt == C_LAST_ADDR) begin
        r_state <= ST_RUN;
      end
    end
  end

  // Registers may hold stale values during the first reset cycle, so gate with rst
  assign w_run        = !rst && (r_state == ST_RUN);
  assign w_occupancy  = r_fifo_cnt + {1'b0, r_rd_pending};
  assign w_req_ready  = w_run && (w_occupancy < 2'd2);
  assign w_accept     = req_valid_i && w_req_ready;

  assign w_fifo_empty = (r_fifo_cnt == 2'd0);
  assign w_rsp_valid  = !rst && (r_rd_pending || !w_fifo_empty);
  assign w_push       = !rst && r_rd_pending && (!w_fifo_empty || !rsp_ready_i);
  assign w_pop        = w_rsp_valid && rsp_ready_i && !w_fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pending <= 1'b0;
      r_fifo_cnt   <= 2'd0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
    end else begin
      r_rd_pending <= w_accept && !req_we_i;
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= ram_rdata_i;
    end
  end

  // Empty FIFO lets the SRAM read data fall straight through to the response
  assign rsp_valid_o = w_rsp_valid;
  assign rsp_rdata_o = w_fifo_empty ? ram_rdata_i : r_fifo_mem[r_rd_ptr];
  assign req_ready_o = w_req_ready;
  assign init_done_o = w_run;

  always_comb begin
    ram_cs_o    = 1'b0;
    ram_we_o    = req_we_i;
    ram_addr_o  = req_addr_i;
    ram_wdata_o = req_wdata_i;
    ram_wmask_o = req_wmask_i;
    if (!rst) begin
      if (r_state == ST_INIT) begin
        ram_cs_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = r_init_cnt;
        ram_wdata_o = '0;
        ram_wmask_o = '1;
      end else begin
        ram_cs_o    = w_accept;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_ram_1rw_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpdcache_ram_1rw_port
// Brief    : Randomized bench for hpdcache_ram_1rw_port with a queue-based
//            transaction model and an attached behavioural 1RW SRAM.
// Revision : 1.0
// ============================================================================
module tb_hpdcache_ram_1rw_port;

  localparam int AW  = 3;
  localparam int DW  = 16;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wmask = '0;
  logic          rsp_ready = 1'b0;

  logic          req_ready, rsp_valid, init_done;
  logic [DW-1:0] rsp_rdata;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_wmask;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] sram [DEP];

  // Second instance without zero-fill, kept idle
  logic          req_ready0, rsp_valid0, init_done0;
  logic [DW-1:0] rsp_rdata0;
  logic          ram_cs0, ram_we0;
  logic [AW-1:0] ram_addr0;
  logic [DW-1:0] ram_wdata0, ram_wmask0;
  logic          idle0 = 1'b0;
  logic          rdy0 = 1'b1;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] zero0 = '0;

  always #5 clk = ~clk;

  hpdcache_ram_1rw_port #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEP), .INIT_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .init_done_o(init_done),
    .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask), .ram_rdata_i(ram_rdata)
  );

  hpdcache_ram_1rw_port #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEP), .INIT_ON_RESET(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(idle0), .req_ready_o(req_ready0), .req_we_i(idle0),
    .req_addr_i(addr0), .req_wdata_i(zero0), .req_wmask_i(zero0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rdy0), .rsp_rdata_o(rsp_rdata0),
    .init_done_o(init_done0),
    .ram_cs_o(ram_cs0), .ram_we_o(ram_we0), .ram_addr_o(ram_addr0),
    .ram_wdata_o(ram_wdata0), .ram_wmask_o(ram_wmask0), .ram_rdata_i(zero0)
  );

  // Behavioural 1RW SRAM: masked write, read data registered
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) sram[ram_addr] <= (sram[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      else        ram_rdata <= sram[ram_addr];
    end
  end

  // Transaction-level model
  int            since_rel = 0;
  logic [DW-1:0] exp_mem [DEP];
  logic [DW-1:0] rq [$];
  int            n_cmp = 0;
  int            n_fail = 0;

  logic          s_ready, s_valid, s_done, s_cs, s_acc;
  logic [DW-1:0] s_rdata;
  logic [AW-1:0] s_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    bit e_init, e_ready, e_valid;
    @(negedge clk);
    s_ready = req_ready; s_valid = rsp_valid; s_done = init_done;
    s_cs = ram_cs; s_rdata = rsp_rdata; s_addr = ram_addr;
    e_init  = !rst && (since_rel < DEP);
    e_ready = !rst && !e_init && (rq.size() < 2);
    e_valid = !rst && !e_init && (rq.size() > 0);
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_done",  init_done, 0);
      chk("rst_cs",    ram_cs, 0);
    end else if (e_init) begin
      chk("init_cs",    ram_cs, 1);
      chk("init_we",    ram_we, 1);
      chk("init_addr",  ram_addr, since_rel);
      chk("init_wdata", ram_wdata, 0);
      chk("init_wmask", ram_wmask, 32'hFFFF);
      chk("init_ready", req_ready, 0);
      chk("init_done",  init_done, 0);
      chk("init_valid", rsp_valid, 0);
    end else begin
      chk("run_ready", req_ready, e_ready);
      chk("run_done",  init_done, 1);
      chk("rsp_valid", rsp_valid, e_valid);
      if (e_valid) chk("rsp_rdata", rsp_rdata, rq[0]);
      chk("run_cs", ram_cs, req_valid && e_ready);
      if (req_valid && e_ready) begin
        chk("cmd_we",    ram_we, req_we);
        chk("cmd_addr",  ram_addr, req_addr);
        chk("cmd_wdata", ram_wdata, req_wdata);
        chk("cmd_wmask", ram_wmask, req_wmask);
      end
    end
    chk("noinit_ready", req_ready0, !rst);
    chk("noinit_done",  init_done0, !rst);
    chk("noinit_cs",    ram_cs0, 0);
    s_acc = req_valid && e_ready;
    @(posedge clk);
    if (rst) begin
      since_rel = 0;
      rq.delete();
    end else if (e_init) begin
      exp_mem[since_rel] = '0;
      since_rel++;
    end else begin
      if (e_valid && rsp_ready) void'(rq.pop_front());
      if (s_acc) begin
        if (req_we) exp_mem[req_addr] = (exp_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
        else        rq.push_back(exp_mem[req_addr]);
      end
    end
    #1;
  endtask

  task automatic issue(input bit we, input int a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_valid = 1'b1; req_we = we; req_addr = a[AW-1:0]; req_wdata = d; req_wmask = m;
    for (int k = 0; k < 50; k++) begin
      step();
      if (s_acc) break;
    end
    if (!s_acc) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_timeout: got no accept, expected accept at t=%0t", $time);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Zero-fill sequence after release
    for (int i = 0; i < DEP; i++) begin
      step();
      if (i == 0) chk("lit_first_init_addr", s_addr, 0);
    end
    step();
    chk("lit_done_after_init",  s_done, 1);
    chk("lit_ready_after_init", s_ready, 1);

    // Masked write then read-back
    issue(1'b1, 5, 16'hABCD, 16'h00FF);
    rsp_ready = 1'b1;
    issue(1'b0, 5, '0, '0);
    step();
    chk("lit_masked_valid", s_valid, 1);
    chk("lit_masked_rdata", s_rdata, 16'h00CD);

    // Backpressure with two outstanding reads
    issue(1'b1, 1, 16'h1111, 16'hFFFF);
    issue(1'b1, 2, 16'h2222, 16'hFFFF);
    rsp_ready = 1'b0;
    issue(1'b0, 1, '0, '0);
    issue(1'b0, 2, '0, '0);
    step();
    chk("lit_bp_ready_low", s_ready, 0);
    chk("lit_bp_hold",      s_rdata, 16'h1111);
    rsp_ready = 1'b1;
    step();
    chk("lit_bp_first",  s_rdata, 16'h1111);
    step();
    chk("lit_bp_second", s_rdata, 16'h2222);
    chk("lit_bp_valid",  s_valid, 1);
    step();
    chk("lit_bp_drained", s_valid, 0);
    chk("lit_bp_ready",   s_ready, 1);

    // Back-to-back reads, one per cycle
    for (int i = 0; i < DEP; i++) issue(1'b1, i, 16'hA000 | 16'(i * 17), 16'hFFFF);
    rsp_ready = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i);
      step();
      chk("lit_b2b_ready", s_ready, 1);
      if (i > 0) chk("lit_b2b_rdata", s_rdata, 16'hA000 | 16'((i - 1) * 17));
    end
    req_valid = 1'b0;
    step();
    chk("lit_b2b_last", s_rdata, 16'hA000 | 16'(7 * 17));

    // Reset in the middle of the zero-fill
    rst = 1'b1; step(); rst = 1'b0;
    step(); step(); step();
    chk("lit_mid_init_addr2", s_addr, 2);
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < DEP; i++) begin
      step();
      chk("lit_restart_addr", s_addr, i);
      chk("lit_restart_cs",   s_cs, 1);
    end
    step();
    chk("lit_restart_done", s_done, 1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = $urandom_range(0, 2) != 0;
      req_we    = $urandom_range(0, 2) == 0;
      req_addr  = AW'($urandom_range(0, DEP - 1));
      req_wdata = DW'($urandom);
      req_wmask = DW'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
